piece_sequencer: RTL and testbench

- Game-flow controller for the 10x20 board store: spawns pieces, applies gravity and player moves, probes the board for collisions, and commits erase/draw writes.
- Runs one probe per cell, serially, through the board's read port.
- On landing, hands off to the line-clear engine through a lock handshake and waits for its completion.
- Sits between the keyboard/input decoder and the board; it is the only writer of board piece-cell updates.

---
 rtl/piece_sequencer_pkg.sv | 36 +++
 rtl/piece_sequencer_if.sv | 37 +++
 rtl/piece_shape_rom.sv | 56 +++++
 rtl/piece_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_piece_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/piece_sequencer_pkg.sv
// Shared types for the game-flow slice: board geometry, move directions,
// cell colors, tetromino identities, and the small helpers used around them.
package piece_sequencer_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;

  typedef enum logic [1:0] {LEFT, RIGHT, DOWN, ROT_CW} direction_t;

  typedef enum logic [2:0] {
    EMPTY, CYAN, YELLOW, PURPLE, GREEN, RED, BLUE, ORANGE
  } block_color_t;

  typedef enum logic [2:0] {
    PIECE_I, PIECE_O, PIECE_T, PIECE_S, PIECE_Z, PIECE_J, PIECE_L
  } piece_t;

  function automatic block_color_t piece_color(input piece_t p);
    case (p)
      PIECE_I: return CYAN;
      PIECE_O: return YELLOW;
      PIECE_T: return PURPLE;
      PIECE_S: return GREEN;
      PIECE_Z: return RED;
      PIECE_J: return BLUE;
      PIECE_L: return ORANGE;
      default: return EMPTY;
    endcase
  endfunction

  // 3-bit maximal-length LFSR (x^3 + x^2 + 1); never reaches 0 from a non-zero seed.
  function automatic logic [2:0] lfsr_next(input logic [2:0] s);
    return {s[1:0], s[2] ^ s[1]};
  endfunction

endpackage

// File: rtl/piece_sequencer_if.sv
// Board / input-decoder / line-clear connection bundle for the piece sequencer.
//   move_req/move_dir/move_ack : player move request handshake
//   probe_x/probe_y/probe_occ  : board read port (combinational occupancy)
//   x_block/y_block            : cells to draw, save_xblock/save_yblock: cells to erase
//   block, wr_en               : draw color and one-cycle write strobe
//   lock_req/lock_done         : line-clear engine handshake
// master = sequencer side, slave = environment side.
interface piece_sequencer_if;
  import piece_sequencer_pkg::*;

  logic         move_req;
  direction_t   move_dir;
  logic         move_ack;
  logic [4:0]   probe_x;
  logic [4:0]   probe_y;
  logic         probe_occ;
  logic [19:0]  x_block;
  logic [19:0]  y_block;
  logic [19:0]  save_xblock;
  logic [19:0]  save_yblock;
  block_color_t block;
  logic         wr_en;
  logic         lock_req;
  logic         lock_done;

  modport master (
    input  move_req, move_dir, probe_occ, lock_done,
    output move_ack, probe_x, probe_y, x_block, y_block,
           save_xblock, save_yblock, block, wr_en, lock_req
  );

  modport slave (
    output move_req, move_dir, probe_occ, lock_done,
    input  move_ack, probe_x, probe_y, x_block, y_block,
           save_xblock, save_yblock, block, wr_en, lock_req
  );
endinterface

// File: rtl/piece_shape_rom.sv
// Combinational tetromino shape lookup: (piece, rotation, ox, oy) -> four
// absolute cells packed 5 bits each, cell0 in [19:15]. Coordinates wrap mod 32,
// so an origin left of column 0 is carried as a large value.
//   piece, rotation : shape selector
//   ox, oy          : 4x4 box origin
//   x_cells/y_cells : packed cell columns / rows
module piece_shape_rom
  import piece_sequencer_pkg::*;
(
  input  piece_t      piece,
  input  logic [1:0]  rotation,
  input  logic [4:0]  ox,
  input  logic [4:0]  oy,
  output logic [19:0] x_cells,
  output logic [19:0] y_cells
);

  logic [15:0] base;   // {dx0,dy0,dx1,dy1,dx2,dy2,dx3,dy3} at rotation 0
  logic [1:0]  span;   // box size - 1 used for rotation
  logic [1:0]  tx, ty, tmp;

  always_comb begin
    span = 2'd2;
    case (piece)
      PIECE_I: begin base = {2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1, 2'd3,2'd1}; span = 2'd3; end
      PIECE_O: base = {2'd1,2'd0, 2'd2,2'd0, 2'd1,2'd1, 2'd2,2'd1};
      PIECE_T: base = {2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
      PIECE_S: base = {2'd1,2'd0, 2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1};
      PIECE_Z: base = {2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd2,2'd1};
      PIECE_J: base = {2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
      PIECE_L: base = {2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1};
      default: base = '0;
    endcase

    x_cells = '0;
    y_cells = '0;
    tx = '0;
    ty = '0;
    tmp = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      tx = base[15-4*i -: 2];
      ty = base[13-4*i -: 2];
      // Clockwise turn inside the box: (x, y) -> (span - y, x); O is symmetric.
      for (int unsigned r = 0; r < 3; r++) begin
        if (2'(r) < rotation && piece != PIECE_O) begin
          tmp = tx;
          tx  = span - ty;
          ty  = tmp;
        end
      end
      x_cells[19-5*i -: 5] = ox + {3'b000, tx};
      y_cells[19-5*i -: 5] = oy + {3'b000, ty};
    end
  end

endmodule

// File: rtl/piece_sequencer.sv
// Game-flow controller: spawns pieces, applies gravity and player moves,
// probes the candidate position cell by cell through the board read port,
// commits erase/draw writes and hands landed pieces to the line-clear engine.
//   Clk, Reset  : clock, synchronous active-high reset
//   frame_tick  : 60 Hz pulse driving gravity
//   start       : leaves WAIT_START
//   game_over   : sticky spawn-collision flag
//   bus         : move handshake, board read/write port, lock handshake
module piece_sequencer
  import piece_sequencer_pkg::*;
#(
  parameter int unsigned GRAVITY_FRAMES = 48,
  parameter int unsigned SPAWN_X        = 3,
  parameter int unsigned SPAWN_Y        = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              start,
  output logic              game_over,
  piece_sequencer_if.master bus
);

  localparam int unsigned GW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_FRAMES - 1);

  typedef enum logic [2:0] {
    WAIT_START, SPAWN, PLAY, PROBE, COMMIT, LOCK, GAME_OVER
  } state_t;

  typedef enum logic [1:0] {TAG_SPAWN, TAG_GRAVITY, TAG_MOVE} tag_t;

  state_t      state;
  tag_t        tag;
  direction_t  cand_dir;
  piece_t      piece;
  logic [2:0]  lfsr;
  logic [GW-1:0] grav_cnt;
  logic [1:0]  rot, cand_rot, probe_idx;
  logic [4:0]  ox, oy, cand_ox, cand_oy;
  logic [19:0] cur_x, cur_y, cand_x, cand_y;
  logic        coll_acc;

  logic [4:0]  cell_x, cell_y;
  logic        is_self, cell_hit, grav_fire, any_hit, down_move;

  piece_shape_rom u_rom (
    .piece    (piece),
    .rotation (cand_rot),
    .ox       (cand_ox),
    .oy       (cand_oy),
    .x_cells  (cand_x),
    .y_cells  (cand_y)
  );

  always_comb begin
    cell_x  = '0;
    cell_y  = '0;
    is_self = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (probe_idx == 2'(i)) begin
        cell_x = cand_x[19-5*i -: 5];
        cell_y = cand_y[19-5*i -: 5];
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (cur_x[19-5*i -: 5] == cell_x && cur_y[19-5*i -: 5] == cell_y)
        is_self = 1'b1;
    end
    // After a lock the old cells belong to the board, so a spawn never excludes them.
    cell_hit = (cell_x >= 5'(BOARD_W)) || (cell_y >= 5'(BOARD_H)) ||
               (bus.probe_occ && !(is_self && tag != TAG_SPAWN));
    any_hit   = coll_acc || cell_hit;
    grav_fire = frame_tick && (grav_cnt == GRAV_LAST);
    down_move = (tag == TAG_GRAVITY) || (tag == TAG_MOVE && cand_dir == DOWN);
  end

  assign bus.probe_x = (state == PROBE) ? cell_x : '0;
  assign bus.probe_y = (state == PROBE) ? cell_y : '0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= WAIT_START;
      tag             <= TAG_SPAWN;
      cand_dir        <= LEFT;
      piece           <= PIECE_I;
      lfsr            <= 3'b001;
      grav_cnt        <= '0;
      rot             <= '0;
      cand_rot        <= '0;
      probe_idx       <= '0;
      ox              <= '0;
      oy              <= '0;
      cand_ox         <= '0;
      cand_oy         <= '0;
      cur_x           <= '0;
      cur_y           <= '0;
      coll_acc        <= 1'b0;
      game_over       <= 1'b0;
      bus.move_ack    <= 1'b0;
      bus.x_block     <= '0;
      bus.y_block     <= '0;
      bus.save_xblock <= '0;
      bus.save_yblock <= '0;
      bus.block       <= EMPTY;
      bus.wr_en       <= 1'b0;
      bus.lock_req    <= 1'b0;
    end else begin
      bus.wr_en    <= 1'b0;
      bus.move_ack <= 1'b0;
      case (state)
        WAIT_START: if (start) state <= SPAWN;

        SPAWN: begin
          piece     <= piece_t'((lfsr == 3'd7) ? 3'd0 : lfsr);
          lfsr      <= lfsr_next(lfsr);
          rot       <= '0;
          cand_rot  <= '0;
          cand_ox   <= 5'(SPAWN_X);
          cand_oy   <= 5'(SPAWN_Y);
          tag       <= TAG_SPAWN;
          probe_idx <= '0;
          coll_acc  <= 1'b0;
          state     <= PROBE;
        end

        PLAY: begin
          cand_rot  <= rot;
          cand_ox   <= ox;
          cand_oy   <= oy;
          probe_idx <= '0;
          coll_acc  <= 1'b0;
          // The counter wraps when gravity fires so it cannot run past the compare value.
          if (frame_tick) grav_cnt <= grav_fire ? '0 : grav_cnt + GW'(1);
          if (grav_fire) begin
            cand_oy <= oy + 5'd1;
            tag     <= TAG_GRAVITY;
            state   <= PROBE;
          end else if (bus.move_req && !bus.move_ack) begin
            // The ack cycle is skipped so a still-held request is not taken twice.
            tag      <= TAG_MOVE;
            cand_dir <= bus.move_dir;
            state    <= PROBE;
            case (bus.move_dir)
              LEFT:   cand_ox  <= ox - 5'd1;
              RIGHT:  cand_ox  <= ox + 5'd1;
              DOWN:   cand_oy  <= oy + 5'd1;
              ROT_CW: cand_rot <= rot + 2'd1;
            endcase
          end
        end

        PROBE: begin
          coll_acc  <= any_hit;
          probe_idx <= probe_idx + 2'd1;
          if (probe_idx == 2'd3) begin
            if (!any_hit) begin
              bus.wr_en       <= 1'b1;
              bus.save_xblock <= (tag == TAG_SPAWN) ? cand_x : cur_x;
              bus.save_yblock <= (tag == TAG_SPAWN) ? cand_y : cur_y;
              bus.x_block     <= cand_x;
              bus.y_block     <= cand_y;
              bus.block       <= piece_color(piece);
              bus.move_ack    <= (tag == TAG_MOVE);
              cur_x <= cand_x;
              cur_y <= cand_y;
              rot   <= cand_rot;
              ox    <= cand_ox;
              oy    <= cand_oy;
              if (down_move) grav_cnt <= '0;
              state <= COMMIT;
            end else if (tag == TAG_SPAWN) begin
              game_over <= 1'b1;
              state     <= GAME_OVER;
            end else if (down_move) begin
              bus.lock_req <= 1'b1;
              bus.move_ack <= (tag == TAG_MOVE);
              state        <= LOCK;
            end else begin
              bus.move_ack <= 1'b1;
              state        <= PLAY;
            end
          end
        end

        COMMIT: state <= PLAY;

        LOCK: begin
          if (bus.lock_done) begin
            bus.lock_req <= 1'b0;
            state        <= SPAWN;
          end
        end

        GAME_OVER: state <= GAME_OVER;

        default: state <= WAIT_START;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_sequencer.sv
// Directed bench for piece_sequencer with a small board model answering probes
// and applying erase-then-draw writes.
module tb_piece_sequencer;
  import piece_sequencer_pkg::*;

  logic Clk = 1'b0;
  logic Reset, frame_tick, start, game_over;
  logic [1:0] board_cmd;   // 0 idle, 1 clear, 2 clear and fill rows 0-1
  logic occ [0:19][0:9];
  int n_checks = 0;
  int n_errors = 0;

  piece_sequencer_if bus ();

  piece_sequencer #(
    .GRAVITY_FRAMES (2),
    .SPAWN_X        (3),
    .SPAWN_Y        (0)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .start      (start),
    .game_over  (game_over),
    .bus        (bus)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    bus.probe_occ = 1'b0;
    if (bus.probe_x < 5'd10 && bus.probe_y < 5'd20)
      bus.probe_occ = occ[bus.probe_y][bus.probe_x];
  end

  always @(posedge Clk) begin
    if (board_cmd != 2'd0) begin
      for (int y = 0; y < 20; y++)
        for (int x = 0; x < 10; x++)
          occ[y][x] <= (board_cmd == 2'd2) && (y < 2);
    end else if (bus.wr_en) begin
      for (int i = 0; i < 4; i++) begin
        int ex, ey;
        ex = int'(bus.save_xblock[19-5*i -: 5]);
        ey = int'(bus.save_yblock[19-5*i -: 5]);
        if (ex < 10 && ey < 20) occ[ey][ex] <= 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        int dx, dy;
        dx = int'(bus.x_block[19-5*i -: 5]);
        dy = int'(bus.y_block[19-5*i -: 5]);
        if (dx < 10 && dy < 20) occ[dy][dx] <= 1'b1;
      end
    end
  end

  function automatic logic [199:0] cell_bit(input int x, input int y);
    logic [199:0] m;
    m = '0;
    if (x >= 0 && x < 10 && y >= 0 && y < 20) m[y*10+x] = 1'b1;
    return m;
  endfunction

  function automatic logic [199:0] cells_mask(input logic [19:0] xs, input logic [19:0] ys);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      m |= cell_bit(int'(xs[19-5*i -: 5]), int'(ys[19-5*i -: 5]));
    return m;
  endfunction

  function automatic logic [199:0] square(input int x, input int y);
    return cell_bit(x, y) | cell_bit(x+1, y) | cell_bit(x, y+1) | cell_bit(x+1, y+1);
  endfunction

  function automatic logic [199:0] board_mask();
    logic [199:0] m;
    m = '0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        if (occ[y][x]) m[y*10+x] = 1'b1;
    return m;
  endfunction

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // sel 0 waits for wr_en, 1 for move_ack; an expired budget counts as a failure.
  task automatic wait_for(input int sel, input int max_cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      tick();
      seen = (sel == 0) ? bus.wr_en : bus.move_ack;
    end
    if (!seen) check({tag, " timeout"}, 1'b0, 1'b1);
  endtask

  task automatic do_move(input direction_t dir, input logic expect_wr, input string tag);
    bus.move_dir = dir;
    bus.move_req = 1'b1;
    repeat (4) tick();
    check({tag, " early ack"}, bus.move_ack, 1'b0);
    tick();
    check({tag, " ack"}, bus.move_ack, 1'b1);
    check({tag, " wr_en"}, bus.wr_en, expect_wr);
    bus.move_req = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [199:0] pmask;
    logic         saw_wr, saw_ack, lock_held;

    Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; board_cmd = 2'd1;
    bus.move_req = 1'b0; bus.move_dir = LEFT; bus.lock_done = 1'b0;
    tick(); tick();
    check("rst wr_en", bus.wr_en, 1'b0);
    check("rst ack", bus.move_ack, 1'b0);
    check("rst lock_req", bus.lock_req, 1'b0);
    check("rst game_over", game_over, 1'b0);
    check("rst block", bus.block, EMPTY);
    check("rst x_block", bus.x_block, 20'd0);
    Reset = 1'b0; board_cmd = 2'd0;
    tick();

    // Spawn O at (3,0)
    start = 1'b1;
    tick();
    start = 1'b0;
    pmask = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      pmask |= cell_bit(int'(bus.probe_x), int'(bus.probe_y));
    end
    check("spawn probes", pmask, square(4, 0));
    check("spawn early wr", bus.wr_en, 1'b0);
    tick();
    check("spawn wr_en", bus.wr_en, 1'b1);
    check("spawn draw", cells_mask(bus.x_block, bus.y_block), square(4, 0));
    check("spawn color", bus.block, YELLOW);
    check("spawn game_over", game_over, 1'b0);
    tick();
    check("wr_en pulse", bus.wr_en, 1'b0);

    // Gravity after two frame ticks
    frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    frame_tick = 1'b1; tick(); frame_tick = 1'b0;
    wait_for(0, 10, "grav");
    check("grav save", cells_mask(bus.save_xblock, bus.save_yblock), square(4, 0));
    check("grav draw", cells_mask(bus.x_block, bus.y_block), square(4, 1));
    tick();

    // Walk to the left wall, then one more LEFT is rejected
    for (int m = 0; m < 4; m++) do_move(LEFT, 1'b1, "left");
    check("left board", board_mask(), square(0, 1));
    do_move(LEFT, 1'b0, "left wall");
    check("left wall board", board_mask(), square(0, 1));

    // Gravity and RIGHT together: gravity commits first
    frame_tick = 1'b1; tick(); frame_tick = 1'b0; tick();
    bus.move_dir = RIGHT; bus.move_req = 1'b1; frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    wait_for(0, 10, "prio grav");
    check("prio no ack", bus.move_ack, 1'b0);
    check("prio grav draw", cells_mask(bus.x_block, bus.y_block), square(0, 2));
    wait_for(1, 15, "prio right");
    check("prio right wr", bus.wr_en, 1'b1);
    check("prio right draw", cells_mask(bus.x_block, bus.y_block), square(1, 2));
    bus.move_req = 1'b0;
    tick();

    // Drop to rows 18-19, then DOWN lands and locks
    for (int m = 0; m < 16; m++) do_move(DOWN, 1'b1, "down");
    check("bottom board", board_mask(), square(1, 18));
    bus.move_dir = DOWN; bus.move_req = 1'b1;
    repeat (5) tick();
    check("land ack", bus.move_ack, 1'b1);
    check("land wr_en", bus.wr_en, 1'b0);
    check("land lock_req", bus.lock_req, 1'b1);
    bus.move_req = 1'b0;
    saw_wr = 1'b0; lock_held = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      saw_wr |= bus.wr_en;
      lock_held &= bus.lock_req;
    end
    check("lock hold", lock_held, 1'b1);
    check("lock no wr", saw_wr, 1'b0);
    bus.lock_done = 1'b1;
    tick();
    bus.lock_done = 1'b0;
    check("lock drop", bus.lock_req, 1'b0);
    repeat (4) tick();
    check("respawn early wr", bus.wr_en, 1'b0);
    tick();
    check("respawn wr", bus.wr_en, 1'b1);
    check("respawn color", bus.block, PURPLE);
    check("respawn draw", cells_mask(bus.x_block, bus.y_block),
          cell_bit(4, 0) | cell_bit(3, 1) | cell_bit(4, 1) | cell_bit(5, 1));
    check("respawn save", cells_mask(bus.save_xblock, bus.save_yblock),
          cell_bit(4, 0) | cell_bit(3, 1) | cell_bit(4, 1) | cell_bit(5, 1));

    // Blocked spawn -> sticky game over
    Reset = 1'b1; board_cmd = 2'd2;
    tick(); tick();
    Reset = 1'b0; board_cmd = 2'd0;
    check("go reset", game_over, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("go early", game_over, 1'b0);
    tick();
    check("go set", game_over, 1'b1);
    check("go no wr", bus.wr_en, 1'b0);
    saw_wr = 1'b0; saw_ack = 1'b0;
    start = 1'b1; bus.move_req = 1'b1; bus.move_dir = DOWN;
    for (int c = 0; c < 20; c++) begin
      frame_tick = c[0];
      tick();
      saw_wr  |= bus.wr_en;
      saw_ack |= bus.move_ack;
    end
    start = 1'b0; bus.move_req = 1'b0; frame_tick = 1'b0;
    check("go sticky", game_over, 1'b1);
    check("go ignore wr", saw_wr, 1'b0);
    check("go ignore ack", saw_ack, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("go cleared", game_over, 1'b0);
    check("go block", bus.block, EMPTY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
